// File: rtl/mem_req_arbiter_pkg.sv
// Shared memory-interface types for the memory request arbiter slice.
package mem_req_arbiter_pkg;

   localparam int unsigned NUM_MEM_TAGS = 15;

   typedef logic [3:0]  MEM_TAG;
   typedef logic [63:0] MEM_BLOCK;

   typedef enum logic [1:0] {
      MEM_NONE  = 2'h0,
      MEM_LOAD  = 2'h1,
      MEM_STORE = 2'h2
   } MEM_COMMAND;

   // Ownership record for one outstanding memory load tag.
   typedef struct packed {
      logic valid;
      logic is_icache;
   } MEM_OWNER_ENTRY;

endpackage

// File: rtl/mem_req_arbiter_tag_owner_table.sv
// Per-tag ownership table: remembers which requester issued each accepted load
// and reports/retires the owner when the matching block comes back.
module mem_tag_owner_table
   import mem_req_arbiter_pkg::*;
#(
   parameter int unsigned NUM_TAGS = NUM_MEM_TAGS
) (
   input  logic   clock,
   input  logic   reset,
   input  logic   alloc_en_i,
   input  MEM_TAG alloc_tag_i,
   input  logic   alloc_is_icache_i,
   input  MEM_TAG lookup_tag_i,
   output logic   hit_o,
   output logic   hit_is_icache_o
);

   MEM_OWNER_ENTRY entries_q [NUM_TAGS+1];
   MEM_OWNER_ENTRY entries_d [NUM_TAGS+1];

   logic lookup_ok;
   logic alloc_ok;

   // Range-check tags and look up the owner of the returning block.
   always_comb begin
      lookup_ok       = (lookup_tag_i != '0) && (32'(lookup_tag_i) <= NUM_TAGS);
      alloc_ok        = (alloc_tag_i  != '0) && (32'(alloc_tag_i)  <= NUM_TAGS);
      hit_o           = 1'b0;
      hit_is_icache_o = 1'b0;
      if (lookup_ok) begin
         hit_o           = entries_q[lookup_tag_i].valid;
         hit_is_icache_o = entries_q[lookup_tag_i].valid & entries_q[lookup_tag_i].is_icache;
      end
   end

   // Retire first, then allocate, so a same-cycle reuse of a tag keeps the new owner.
   always_comb begin
      entries_d = entries_q;
      if (hit_o) begin
         entries_d[lookup_tag_i].valid = 1'b0;
      end
      if (alloc_en_i && alloc_ok) begin
         entries_d[alloc_tag_i] = '{valid: 1'b1, is_icache: alloc_is_icache_i};
      end
   end

   // Table storage; reset invalidates every tag so stale returns are dropped.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i <= NUM_TAGS; i++) begin
            entries_q[i] <= '0;
         end
      end else begin
         entries_q <= entries_d;
      end
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates the single memory port between dcache (priority) and icache,
// bounded by an anti-starvation counter and an icache outstanding cap, and
// routes returned blocks back to the owning requester.
module mem_req_arbiter
   import mem_req_arbiter_pkg::*;
#(
   parameter int unsigned NUM_TAGS           = NUM_MEM_TAGS,
   parameter int unsigned STARVE_LIMIT       = 4,
   parameter int unsigned IC_MAX_OUTSTANDING = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ic_req_valid,
   input  logic [31:0] ic_req_addr,
   output logic        ic_req_accepted,
   input  MEM_COMMAND  dc_req_command,
   input  logic [31:0] dc_req_addr,
   input  MEM_BLOCK    dc_req_data,
   output logic        dc_req_accepted,
   output MEM_TAG      req_tag,
   output MEM_COMMAND  proc2mem_command,
   output logic [31:0] proc2mem_addr,
   output MEM_BLOCK    proc2mem_data,
   input  MEM_TAG      mem2proc_transaction_tag,
   input  MEM_BLOCK    mem2proc_data,
   input  MEM_TAG      mem2proc_data_tag,
   output logic        ic_resp_valid,
   output logic        dc_resp_valid,
   output MEM_TAG      resp_tag,
   output MEM_BLOCK    resp_data
);

   localparam int unsigned OUT_W = $clog2(IC_MAX_OUTSTANDING + 1);
   localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [OUT_W-1:0] IC_MAX     = OUT_W'(IC_MAX_OUTSTANDING);
   localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

   logic [OUT_W-1:0] ic_out_q, ic_out_d;
   logic [STV_W-1:0] starve_q, starve_d;

   logic ic_eff, force_ic, ic_win, dc_win, accepted;
   logic alloc_en;
   logic hit, hit_is_icache;

   // Same-cycle arbitration and memory request mux.
   always_comb begin
      ic_eff   = ic_req_valid && (ic_out_q < IC_MAX);
      force_ic = (starve_q == STARVE_MAX);
      ic_win   = ic_eff && (force_ic || (dc_req_command == MEM_NONE));
      dc_win   = !ic_win && (dc_req_command != MEM_NONE);
      accepted = (ic_win || dc_win) && (mem2proc_transaction_tag != '0);

      ic_req_accepted  = ic_win && accepted;
      dc_req_accepted  = dc_win && accepted;
      req_tag          = mem2proc_transaction_tag;

      proc2mem_command = MEM_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
      if (ic_win) begin
         proc2mem_command = MEM_LOAD;
         proc2mem_addr    = ic_req_addr;
      end else if (dc_win) begin
         proc2mem_command = dc_req_command;
         proc2mem_addr    = dc_req_addr;
         proc2mem_data    = dc_req_data;
      end

      alloc_en = accepted && (proc2mem_command == MEM_LOAD);
   end

   mem_tag_owner_table #(
      .NUM_TAGS (NUM_TAGS)
   ) u_owner_table (
      .clock             (clock),
      .reset             (reset),
      .alloc_en_i        (alloc_en),
      .alloc_tag_i       (mem2proc_transaction_tag),
      .alloc_is_icache_i (ic_win),
      .lookup_tag_i      (mem2proc_data_tag),
      .hit_o             (hit),
      .hit_is_icache_o   (hit_is_icache)
   );

   // Route a returned block to whichever side owns its tag.
   always_comb begin
      ic_resp_valid = hit && hit_is_icache;
      dc_resp_valid = hit && !hit_is_icache;
      resp_tag      = hit ? mem2proc_data_tag : '0;
      resp_data     = hit ? mem2proc_data     : '0;
   end

   // Outstanding-icache and starvation counter next state.
   always_comb begin
      ic_out_d = ic_out_q;
      case ({ic_req_accepted, ic_resp_valid})
         2'b10:   if (ic_out_q != IC_MAX) ic_out_d = ic_out_q + 1'b1;
         2'b01:   if (ic_out_q != '0)     ic_out_d = ic_out_q - 1'b1;
         default: ic_out_d = ic_out_q;
      endcase

      starve_d = starve_q;
      if (ic_req_accepted) begin
         starve_d = '0;
      end else if (ic_eff && dc_win && (starve_q != STARVE_MAX)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   // Counter registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         ic_out_q <= '0;
         starve_q <= '0;
      end else begin
         ic_out_q <= ic_out_d;
         starve_q <= starve_d;
      end
   end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Sits directly downstream of the icache subsystem and the dcache, in front of the single memory port (mem.sv).
- Each cycle, grants the memory port to one requester:
  - dcache has priority.
  - An anti-starvation counter and an icache outstanding-request cap bound the priority.
- Records which requester owns each accepted load tag, and routes each returned block (mem_data, mem_data_tag) to the owning side as a validated response.

Parameters:
- NUM_TAGS, `NUM_MEM_TAGS (15): memory tags 1..NUM_TAGS; tag 0 means none/rejected.
- STARVE_LIMIT, 4: consecutive icache losses before icache is forced priority.
- IC_MAX_OUTSTANDING, 8: maximum icache loads in flight.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ic_req_valid  in  1  icache load request
- ic_req_addr  in  32  icache block address
- ic_req_accepted  out  1  icache request taken this cycle
- dc_req_command  in  2  MEM_COMMAND: MEM_NONE / MEM_LOAD / MEM_STORE
- dc_req_addr  in  32  dcache address
- dc_req_data  in  64  store data (MEM_BLOCK)
- dc_req_accepted  out  1  dcache request taken this cycle
- req_tag  out  4  MEM_TAG returned by memory this cycle; valid only with an accepted flag
- proc2mem_command  out  2  command to memory
- proc2mem_addr  out  32  address to memory
- proc2mem_data  out  64  store data to memory
- mem2proc_transaction_tag  in  4  nonzero = memory accepted the request this cycle
- mem2proc_data  in  64  returned block
- mem2proc_data_tag  in  4  tag of returned block; 0 = none
- ic_resp_valid  out  1  returned block belongs to icache
- dc_resp_valid  out  1  returned block belongs to dcache
- resp_tag  out  4  tag of the routed response
- resp_data  out  64  routed block

Behaviour:
- Arbitration (combinational, same cycle):
  - ic_eff = ic_req_valid & (ic_outstanding < IC_MAX_OUTSTANDING).
  - force_ic = starve_cnt == STARVE_LIMIT.
  - Icache wins if ic_eff & (force_ic | dc_req_command == MEM_NONE); otherwise dcache wins if dc_req_command != MEM_NONE.
  - No winner: proc2mem_command = MEM_NONE, addr and data = 0.
- Icache grant drives MEM_LOAD, ic_req_addr, data 0.
- Acceptance:
  - accepted = winner present & mem2proc_transaction_tag != 0.
  - Only the winner's *_accepted flag asserts. req_tag = mem2proc_transaction_tag.
  - A rejected winner simply retries; no state changes except starve_cnt.
- Owner table: per tag 1..NUM_TAGS, {valid, is_icache}.
  - On accepted MEM_LOAD: entry[tag] <= {1, winner==icache}.
  - Stores allocate nothing and produce no response.
- Response routing (combinational):
  - When mem2proc_data_tag != 0 and entry[tag].valid: assert ic_resp_valid or dc_resp_valid per is_icache, with resp_tag = mem2proc_data_tag and resp_data = mem2proc_data.
  - The entry clears next edge.
  - Unowned or zero tag: no response, table unchanged.
- Same tag retired and re-allocated in one cycle: the response routes using the old owner; the new allocation wins in the table.
- ic_outstanding:
  - +1 on accepted icache load, −1 on routed icache response.
  - Simultaneous +1/−1 leaves it unchanged.
  - Never exceeds IC_MAX_OUTSTANDING; never underflows.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) when ic_eff and dcache wins.
  - Clears on icache accepted.
  - Holds otherwise, including when icache wins but is rejected.
- Reset:
  - All owner entries invalid; ic_outstanding = 0; starve_cnt = 0.
  - All outputs derive combinationally: 0 / MEM_NONE with inputs idle.
  - Responses arriving after reset for pre-reset tags are dropped.

Decomposition:
- Shared package (sys_defs.svh): MEM_TAG, MEM_BLOCK, MEM_COMMAND, `NUM_MEM_TAGS. Add new typedef MEM_OWNER_ENTRY {valid, is_icache}.
- One natural sub-module: mem_tag_owner_table (allocate port, lookup/retire port, NUM_TAGS entries). Arbitration and counters stay in the top.

Test Plan:
- Icache-only load at 0x100 with memory tag 3 → proc2mem_command=LOAD, addr 0x100, ic_req_accepted=1, req_tag=3. Later data_tag=3, data 0xDEADBEEF → ic_resp_valid=1, resp_data 0xDEADBEEF, dc_resp_valid=0.
- Icache and dcache load requesting every cycle, memory always accepting → 4 dcache grants, then 1 icache grant, pattern repeats; starve_cnt returns to 0 after each icache grant.
- Dcache store with tag 5 accepted, then data_tag=5 → no response asserted on either side.
- 8 icache loads accepted with no responses → 9th request never granted, proc2mem_command=NONE. One response returns → next icache request granted.
- Memory rejects (transaction_tag 0) an icache-winning request for 3 cycles → no accepted flags, counters unchanged, accepted on cycle 4.
- Reset asserted with tags 2 and 7 outstanding; data_tag=2 arrives post-reset → no response. Simultaneous retire of tag 4 (dcache owner) and new icache allocation of tag 4 → dc_resp_valid=1, a later tag-4 response goes to icache.
